operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
Upstream stage of the 4-bit ripple-carry adder. Collects both adder operands and the carry-in from one shared switch bus, using two successive pushbutton presses. Presents the captured triple to the adder with a valid/ready handshake and holds it stable until the handshake completes. Also keeps a transaction counter and a sticky overrun flag for board-level debug on LEDs.

Parameters:
WIDTH, 4, operand width in bits; must match the adder width.
SYNC_STAGES, 2, synchroniser flops on the asynchronous pushbutton input (minimum 2).
CNT_WIDTH, 8, width of the completed-transaction counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
key_n  in  1  pushbutton, active-low, asynchronous to clk.
data_in  in  WIDTH  switch bus; carries operand A, then operand B.
cin_in  in  1  carry-in switch; sampled with operand B.
op_a  out  WIDTH  captured operand A to adder.
op_b  out  WIDTH  captured operand B to adder.
op_cin  out  1  captured carry-in to adder.
op_valid  out  1  operands stable and offered downstream.
op_ready  in  1  downstream accepts; transfer occurs on a clk edge when op_valid and op_ready are both 1.
state_dbg  out  2  current FSM state encoding.
txn_count  out  CNT_WIDTH  number of completed transfers, wraps.
err_overrun  out  1  sticky; a press arrived while operands were being presented.

Behaviour:
- Reset (sync, rst=1 at an edge): op_a=0, op_b=0, op_cin=0, op_valid=0, txn_count=0, err_overrun=0, state=WAIT_A.
  - All synchroniser flops and the edge-detect flop reset to 1 (key released).
- Press detection:
  - key_n passes through SYNC_STAGES flops, then one history flop.
  - press = history & ~sync_out, a one-cycle pulse per falling edge.
  - A key_n fall before edge k is acted on at edge k+SYNC_STAGES (3rd edge for default).
  - A key held through reset yields exactly one press after rst deasserts.
  - No debounce. Bounce produces extra presses; the bench drives clean edges.
- FSM states: WAIT_A=2'd0, WAIT_B=2'd1, PRESENT=2'd2. Code 2'd3 is illegal and returns to WAIT_A on the next edge with no output change.
  - WAIT_A, press: op_a<=data_in; go to WAIT_B.
  - WAIT_B, press: op_b<=data_in, op_cin<=cin_in; go to PRESENT; op_valid<=1 on the same edge.
  - PRESENT, op_ready=1: transfer. op_valid<=0, txn_count<=txn_count+1 (wraps 2^CNT_WIDTH-1 -> 0), go to WAIT_A.
  - PRESENT, op_ready=0: hold. op_a, op_b, op_cin and op_valid are unchanged.
  - PRESENT, press (with or without ready): the press is discarded and err_overrun<=1. If ready is also high, the transfer still completes normally.
- op_ready is ignored outside PRESENT. op_valid is never 1 outside PRESENT.
- op_a, op_b and op_cin keep their last values after a transfer until overwritten by the next capture. They are not cleared.
- err_overrun is cleared only by rst.
- Reset mid-operation (any state): full reset values apply at that edge. Partially captured operands are lost.
- Throughput: a minimum of 2 presses plus 1 handshake cycle per transfer. There is no back-to-back pipelining.

Decomposition:
- Shared package: state encodings (WAIT_A, WAIT_B, PRESENT), default WIDTH=4, default CNT_WIDTH=8.
- Sub-module key_edge_sync: SYNC_STAGES synchroniser plus history flop, producing the press pulse.
- The FSM, operand registers, counter and flag live in operand_sequencer.

Test Plan:
1. Reset then idle. Assert rst for 2 edges, key_n=1 -> all outputs 0, state_dbg=0, op_valid=0 for 20 cycles.
2. Basic load. Press with data_in=4'h5, then press with data_in=4'hA, cin_in=1, op_ready=0 -> op_a=5, op_b=A, op_cin=1. op_valid rises at the 3rd edge after the second key fall and stays 1 for 10 cycles.
3. Handshake. From scenario 2, raise op_ready for 1 cycle -> op_valid=0 the next cycle, txn_count=1, state_dbg=0, op_a/op_b still 5/A.
4. Overrun. In PRESENT with op_ready=0, press with data_in=4'h3 -> err_overrun=1, op_a=5 unchanged. Then op_ready=1 -> transfer completes. err_overrun stays 1 until rst.
5. Wrap. Run 256 complete transfers -> txn_count returns to 0 with no other side effects.
6. Reset mid-op. In WAIT_B after capturing A=4'hF, assert rst -> op_a=0, state_dbg=0. The next two presses load fresh operands correctly.

Source files
------------

// File: rtl/operand_sequencer_pkg.sv
// Shared types and default sizes for the operand sequencer that feeds the 4-bit adder.
// Shared by the sequencer top, its key synchroniser and the board-level wrapper.
package operand_sequencer_pkg;

    localparam int DEFAULT_WIDTH       = 4;
    localparam int DEFAULT_CNT_WIDTH   = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Code 2'd3 is never entered on purpose; the FSM treats it as a fault and recovers.
    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        PRESENT = 2'd2,
        ILLEGAL = 2'd3
    } seq_state_t;

endpackage

// File: rtl/operand_sequencer_key_edge_sync.sv
// Brings the asynchronous active-low pushbutton into the clock domain and
// produces a single-cycle press pulse for each falling edge of the key.
module key_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Reset to the released level so a key held through reset still yields one press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/operand_sequencer.sv
// Collects operand A, operand B and carry-in from one switch bus over two key
// presses and offers them to the adder with a valid/ready handshake.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 cin_in,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic                 op_cin,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [1:0]           state_dbg,
    output logic [CNT_WIDTH-1:0] txn_count,
    output logic                 err_overrun
);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [WIDTH-1:0]     op_a_d;
    logic [WIDTH-1:0]     op_b_d;
    logic                 op_cin_d;
    logic                 op_valid_d;
    logic [CNT_WIDTH-1:0] txn_count_d;
    logic                 err_overrun_d;
    logic                 press;

    key_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_A;
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            op_valid    <= 1'b0;
            txn_count   <= '0;
            err_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a        <= op_a_d;
            op_b        <= op_b_d;
            op_cin      <= op_cin_d;
            op_valid    <= op_valid_d;
            txn_count   <= txn_count_d;
            err_overrun <= err_overrun_d;
        end
    end

    // Operands are deliberately held after a transfer; only the next capture replaces them.
    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a;
        op_b_d        = op_b;
        op_cin_d      = op_cin;
        op_valid_d    = op_valid;
        txn_count_d   = txn_count;
        err_overrun_d = err_overrun;

        case (state_q)
            WAIT_A: begin
                if (press) begin
                    op_a_d  = data_in;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    op_b_d     = data_in;
                    op_cin_d   = cin_in;
                    op_valid_d = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (press) begin
                    err_overrun_d = 1'b1;
                end
                if (op_ready) begin
                    op_valid_d  = 1'b0;
                    txn_count_d = txn_count + 1'b1;
                    state_d     = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomised bench for operand_sequencer, checked every cycle against a
// transaction-level model of the press/capture/handshake rules.
module tb_operand_sequencer;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_WIDTH   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 key_n;
    logic [WIDTH-1:0]     data_in;
    logic                 cin_in;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_cin;
    logic                 op_valid;
    logic                 op_ready;
    logic [1:0]           state_dbg;
    logic [CNT_WIDTH-1:0] txn_count;
    logic                 err_overrun;

    int checks = 0;
    int errors = 0;

    int               m_phase;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic             m_cin;
    int               m_count;
    logic             m_err;
    int               pend;
    bit               rand_ready;
    logic [WIDTH-1:0] held_val;

    always #5 clk = ~clk;

    operand_sequencer #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .data_in     (data_in),
        .cin_in      (cin_in),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .state_dbg   (state_dbg),
        .txn_count   (txn_count),
        .err_overrun (err_overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // A key fall (or a key still held as reset releases) takes effect on the
    // (SYNC_STAGES+1)-th non-reset edge after it.
    task automatic tick();
        logic             r;
        logic             kl;
        logic             rdy;
        logic             c;
        logic [WIDTH-1:0] d;
        bit               p;
        r   = rst;
        kl  = ~key_n;
        rdy = op_ready;
        d   = data_in;
        c   = cin_in;
        p   = 1'b0;
        if (r) begin
            pend = kl ? SYNC_STAGES + 1 : 0;
        end else if (pend > 0) begin
            pend--;
            p = (pend == 0);
        end
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_a = '0; m_b = '0; m_cin = 1'b0; m_count = 0; m_err = 1'b0;
        end else begin
            case (m_phase)
                0: if (p) begin m_a = d; m_phase = 1; end
                1: if (p) begin m_b = d; m_cin = c; m_phase = 2; end
                default: begin
                    if (p) m_err = 1'b1;
                    if (rdy) begin
                        m_count = (m_count + 1) % (1 << CNT_WIDTH);
                        m_phase = 0;
                    end
                end
            endcase
        end
        #1;
        checkOutput("op_a", op_a, m_a);
        checkOutput("op_b", op_b, m_b);
        checkOutput("op_cin", op_cin, m_cin);
        checkOutput("op_valid", op_valid, (m_phase == 2));
        checkOutput("state_dbg", state_dbg, m_phase);
        checkOutput("txn_count", txn_count, m_count);
        checkOutput("err_overrun", err_overrun, m_err);
        if (rand_ready) op_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic c);
        data_in = d;
        cin_in  = c;
        key_n   = 1'b0;
        pend    = SYNC_STAGES + 1;
        repeat (4) tick();
        key_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; key_n = 1'b1; data_in = '0; cin_in = 1'b0; op_ready = 1'b0;
        rand_ready = 1'b0; pend = 0;
        m_phase = 0; m_a = '0; m_b = '0; m_cin = 1'b0; m_count = 0; m_err = 1'b0;

        $display("[TB] reset and idle");
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        checkOutput("idle_valid", op_valid, 0);

        $display("[TB] basic load");
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'hA, 1'b1);
        repeat (10) tick();
        checkOutput("load_a", op_a, 4'h5);
        checkOutput("load_b", op_b, 4'hA);
        checkOutput("load_cin", op_cin, 1);
        checkOutput("load_valid", op_valid, 1);

        $display("[TB] handshake");
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        tick();
        checkOutput("hs_valid", op_valid, 0);
        checkOutput("hs_count", txn_count, 1);
        checkOutput("hs_state", state_dbg, 0);
        checkOutput("hs_a_kept", op_a, 4'h5);
        checkOutput("hs_b_kept", op_b, 4'hA);

        $display("[TB] overrun");
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'hA, 1'b1);
        applyStimulus(4'h3, 1'b0);
        checkOutput("ovr_flag", err_overrun, 1);
        checkOutput("ovr_a_kept", op_a, 4'h5);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        repeat (5) tick();
        checkOutput("ovr_count", txn_count, 2);
        checkOutput("ovr_sticky", err_overrun, 1);

        $display("[TB] reset mid-operation");
        applyStimulus(4'hF, 1'b0);
        checkOutput("mid_state", state_dbg, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_a_cleared", op_a, 0);
        checkOutput("mid_state_rst", state_dbg, 0);
        checkOutput("mid_err_cleared", err_overrun, 0);
        applyStimulus(4'h6, 1'b0);
        applyStimulus(4'h9, 1'b1);
        checkOutput("mid_fresh_a", op_a, 4'h6);
        checkOutput("mid_fresh_b", op_b, 4'h9);

        $display("[TB] key held through reset");
        held_val = 4'hC;
        data_in  = held_val;
        key_n    = 1'b0;
        rst      = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        key_n = 1'b1;
        repeat (4) tick();
        checkOutput("held_state", state_dbg, 1);
        checkOutput("held_a", op_a, held_val);

        $display("[TB] counter wrap");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(4'($urandom), 1'($urandom));
            applyStimulus(4'($urandom), 1'($urandom));
        end
        op_ready = 1'b0;
        tick();
        checkOutput("wrap_count", txn_count, 0);
        checkOutput("wrap_err", err_overrun, 0);

        $display("[TB] random traffic");
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        op_ready   = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
